// File: rtl/fifo_umbrales_pkg.sv
// Shared definitions for the lane FIFO and the switch controller: default widths,
// controller state encodings, threshold width and the watermark flag computation.
package fifo_umbrales_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int ADDR_W_DEF = 2;
  localparam int UMBRAL_W   = 8;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } flags_t;

  // Occupancy is zero-extended to the threshold width so out-of-range thresholds
  // naturally pin almost_full low (alto > depth) or almost_empty high (bajo >= depth).
  function automatic flags_t calc_flags(input logic [UMBRAL_W-1:0] cnt,
                                        input logic [UMBRAL_W-1:0] depth,
                                        input logic [UMBRAL_W-1:0] bajo,
                                        input logic [UMBRAL_W-1:0] alto);
    flags_t f;
    f.empty        = (cnt == '0);
    f.full         = (cnt == depth);
    f.almost_empty = (cnt <= bajo);
    f.almost_full  = (cnt >= alto);
    return f;
  endfunction

endpackage

// File: rtl/fifo_umbrales_if.sv
// Lane-side bus of the watermark FIFO: write/read handshake, thresholds and status.
interface fifo_umbrales_if
  import fifo_umbrales_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic                push;
  logic [DATA_W-1:0]   data_in;
  logic                pop;
  logic [UMBRAL_W-1:0] umbral_bajo;
  logic [UMBRAL_W-1:0] umbral_alto;
  logic [DATA_W-1:0]   data_out;
  logic                valid_out;
  logic                empty;
  logic                full;
  logic                almost_empty;
  logic                almost_full;
  logic                error;

  modport master (
    output push, data_in, pop, umbral_bajo, umbral_alto,
    input  data_out, valid_out, empty, full, almost_empty, almost_full, error
  );

  modport slave (
    input  push, data_in, pop, umbral_bajo, umbral_alto,
    output data_out, valid_out, empty, full, almost_empty, almost_full, error
  );
endinterface

// File: rtl/fifo_umbrales_memoria_dual.sv
// DEPTH x DATA_W register file: synchronous write port, registered read port.
// Storage is never reset; only the read register returns to zero.
module memoria_dual #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DATA_W-1:0]            rd_data_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end

  // Read samples the pre-write contents, so a read and write to the same slot
  // (push & pop while full) returns the oldest word.
  always_ff @(posedge clk) begin
    if (reset)   rd_data_q <= '0;
    else if (re) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/fifo_umbrales.sv
// Single-clock lane FIFO with programmable low/high watermarks and a sticky
// overflow/underflow flag. Flags are registered from the next occupancy.
module fifo_umbrales
  import fifo_umbrales_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic             clk,
  input logic             reset,
  fifo_umbrales_if.slave  bus
);
  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  flags_t            flags_q, flags_d;
  logic              error_q, error_d;
  logic              valid_q, valid_d;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] rd_data;

  // A push into a full FIFO is still taken when a pop frees the slot this edge.
  assign wr_ok = bus.push & (~flags_q.full | bus.pop);
  assign rd_ok = bus.pop & ~flags_q.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q;
    valid_d  = 1'b0;
    if (reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      error_d  = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
      valid_d = rd_ok;
      error_d = error_q | (bus.push & flags_q.full & ~bus.pop)
                        | (bus.pop & flags_q.empty);
    end
    flags_d = calc_flags(UMBRAL_W'(count_d), UMBRAL_W'(DEPTH),
                         bus.umbral_bajo, bus.umbral_alto);
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    flags_q  <= flags_d;
    error_q  <= error_d;
    valid_q  <= valid_d;
  end

  memoria_dual #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_ok & ~reset),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.data_in),
    .re      (rd_ok & ~reset),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign bus.data_out     = rd_data;
  assign bus.valid_out    = valid_q;
  assign bus.empty        = flags_q.empty;
  assign bus.full         = flags_q.full;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.almost_full  = flags_q.almost_full;
  assign bus.error        = error_q;
endmodule

// File: tb/tb_fifo_umbrales.sv
// Self-checking bench for fifo_umbrales: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_fifo_umbrales;
  localparam int DATA_W = 6;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;

  fifo_umbrales_if #(.DATA_W(DATA_W)) bus ();

  fifo_umbrales #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference model
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_dout;
  logic              m_vld;
  logic              m_err;
  logic [7:0]        m_bajo, m_alto;

  function automatic logic [4:0] exp_flags();
    int n = m_q.size();
    return {n == 0, n == DEPTH, n <= int'(m_bajo), n >= int'(m_alto), m_err};
  endfunction

  // Apply one cycle of inputs, advance the model, and land 1 time unit past the edge.
  task automatic cyc(input bit rst, input bit ps, input logic [DATA_W-1:0] d, input bit pp);
    bit was_full, was_empty;
    reset = rst; bus.push = ps; bus.data_in = d; bus.pop = pp;
    m_bajo = bus.umbral_bajo; m_alto = bus.umbral_alto;
    if (rst) begin
      m_q.delete(); m_err = 0; m_dout = '0; m_vld = 0;
    end else begin
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      if ((ps && was_full && !pp) || (pp && was_empty)) m_err = 1;
      if (pp && !was_empty) begin m_dout = m_q.pop_front(); m_vld = 1; end
      else m_vld = 0;
      if (ps && (!was_full || pp)) m_q.push_back(d);
    end
    @(posedge clk); #1;
    reset = 0; bus.push = 0; bus.pop = 0;
  endtask

  task automatic test_reset();
    bus.umbral_bajo = 8'd1; bus.umbral_alto = 8'd3;
    cyc(1, 0, '0, 0);
    cyc(1, 0, '0, 0);
    total++; if (bus.empty !== 1'b1) $display("FAIL rst_empty got=%b exp=1", bus.empty); else passed++;
    total++; if (bus.almost_empty !== 1'b1) $display("FAIL rst_aempty got=%b exp=1", bus.almost_empty); else passed++;
    total++; if (bus.almost_full !== 1'b0) $display("FAIL rst_afull got=%b exp=0", bus.almost_full); else passed++;
    total++; if (bus.full !== 1'b0) $display("FAIL rst_full got=%b exp=0", bus.full); else passed++;
    total++; if (bus.error !== 1'b0) $display("FAIL rst_error got=%b exp=0", bus.error); else passed++;
    total++; if (bus.valid_out !== 1'b0) $display("FAIL rst_valid got=%b exp=0", bus.valid_out); else passed++;
    total++; if (bus.data_out !== 6'h00) $display("FAIL rst_data got=%h exp=00", bus.data_out); else passed++;
  endtask

  task automatic test_fill_drain();
    logic [DATA_W-1:0] w [4] = '{6'h11, 6'h22, 6'h33, 6'h2C};
    logic [3:0] ae_exp = 4'b0001;  // bit i: almost_empty after push i+1 (bajo=1)
    logic [3:0] af_exp = 4'b1100;  // almost_full from the 3rd push (alto=3)
    logic [3:0] fu_exp = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, w[i], 0);
      total++; if ({bus.almost_empty, bus.almost_full, bus.full} !== {ae_exp[i], af_exp[i], fu_exp[i]})
        $display("FAIL fill_flags[%0d] got=%b%b%b exp=%b%b%b", i, bus.almost_empty, bus.almost_full,
                 bus.full, ae_exp[i], af_exp[i], fu_exp[i]);
      else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, '0, 1);
      total++; if ({bus.valid_out, bus.data_out} !== {1'b1, w[i]})
        $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, bus.valid_out, bus.data_out, w[i]);
      else passed++;
    end
    total++; if ({bus.empty, bus.error} !== 2'b10) $display("FAIL drain_empty got=%b%b exp=10", bus.empty, bus.error); else passed++;
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] w [4] = '{6'h01, 6'h12, 6'h23, 6'h34};
    for (int i = 0; i < 4; i++) cyc(0, 1, w[i], 0);
    cyc(0, 1, 6'h3F, 0);
    total++; if ({bus.error, bus.full} !== 2'b11) $display("FAIL ovf_err_full got=%b%b exp=11", bus.error, bus.full); else passed++;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, '0, 1);
      total++; if (bus.data_out !== w[i]) $display("FAIL ovf_data[%0d] got=%h exp=%h", i, bus.data_out, w[i]); else passed++;
    end
    total++; if (bus.empty !== 1'b1) $display("FAIL ovf_empty got=%b exp=1", bus.empty); else passed++;
  endtask

  task automatic test_underflow_wrap();
    logic [DATA_W-1:0] d;
    cyc(1, 0, '0, 0);
    cyc(0, 0, '0, 1);
    total++; if ({bus.valid_out, bus.error} !== 2'b01) $display("FAIL udf got=%b%b exp=01", bus.valid_out, bus.error); else passed++;
    for (int i = 0; i < 6; i++) begin
      d = DATA_W'($urandom);
      cyc(0, 1, d, 0);
      cyc(0, 0, '0, 1);
      total++; if ({bus.valid_out, bus.data_out} !== {1'b1, d})
        $display("FAIL wrap[%0d] got=%b/%h exp=1/%h", i, bus.valid_out, bus.data_out, d);
      else passed++;
    end
  endtask

  task automatic test_simul_full();
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, DATA_W'(6'h08 + i), 0);
    cyc(0, 1, 6'h05, 1);
    total++; if ({bus.valid_out, bus.data_out, bus.full, bus.error} !== {1'b1, 6'h08, 1'b1, 1'b0})
      $display("FAIL simul_full got=%b/%h/%b/%b exp=1/08/1/0", bus.valid_out, bus.data_out, bus.full, bus.error);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, '0, 1);
      total++; if (bus.data_out !== m_dout) $display("FAIL simul_drain[%0d] got=%h exp=%h", i, bus.data_out, m_dout); else passed++;
    end
    total++; if (bus.data_out !== 6'h05) $display("FAIL simul_last got=%h exp=05", bus.data_out); else passed++;
  endtask

  task automatic test_midop_reset();
    cyc(0, 0, '0, 1);  // leave error set so reset is seen to clear it
    for (int i = 0; i < 3; i++) cyc(0, 1, DATA_W'(i + 1), 0);
    cyc(1, 1, 6'h2A, 0);
    total++; if ({bus.empty, bus.error, bus.full} !== 3'b100)
      $display("FAIL midrst got=%b%b%b exp=100", bus.empty, bus.error, bus.full);
    else passed++;
    cyc(0, 0, '0, 1);
    total++; if ({bus.valid_out, bus.error} !== 2'b01) $display("FAIL midrst_pop got=%b%b exp=01", bus.valid_out, bus.error); else passed++;
  endtask

  task automatic test_random();
    bit rst, ps, pp;
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) begin
        bus.umbral_bajo = 8'($urandom_range(0, 6));
        bus.umbral_alto = 8'($urandom_range(0, 6));
      end
      rst = ($urandom_range(0, 40) == 0);
      ps  = ($urandom_range(0, 99) < 55);
      pp  = ($urandom_range(0, 99) < 45);
      cyc(rst, ps, DATA_W'($urandom), pp);
      total++;
      if ({bus.empty, bus.full, bus.almost_empty, bus.almost_full, bus.error, bus.valid_out, bus.data_out}
          !== {exp_flags(), m_vld, m_dout})
        $display("FAIL rand[%0d] got=%b%b%b%b%b/%b/%h exp=%b/%b/%h", i, bus.empty, bus.full,
                 bus.almost_empty, bus.almost_full, bus.error, bus.valid_out, bus.data_out,
                 exp_flags(), m_vld, m_dout);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1; bus.push = 0; bus.pop = 0; bus.data_in = '0;
    bus.umbral_bajo = 8'd1; bus.umbral_alto = 8'd3;
    m_err = 0; m_vld = 0; m_dout = '0; m_bajo = 8'd1; m_alto = 8'd3;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow_wrap();
    test_simul_full();
    test_midop_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
